bit_serial_adder: RTL and testbench

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/serial_arith_pkg.sv | 18 +
 rtl/bit_serial_adder_if.sv | 37 +++
 rtl/pg_bit_cell.sv | 17 +
 rtl/bit_serial_adder.sv | 139 +++++++++++++
 tb/tb_bit_serial_adder.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding,
// default operand width and a counter-sizing helper.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bits needed for a counter that must be able to hold the value 'width'.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_serial_adder_if.sv
// Request/result bundle of the bit-serial adder.
// The sub signal exists only when BIT_SERIAL_ADDER_SUB_EN is defined.
interface bit_serial_adder_if
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             prop_all;

    modport master (
        output start, a, b,
`ifdef BIT_SERIAL_ADDER_SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout, prop_all
    );

    modport slave (
        input  start, a, b,
`ifdef BIT_SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout, prop_all
    );

endinterface

// File: rtl/pg_bit_cell.sv
// One-bit propagate/generate full-adder cell used by the serial datapath.
module pg_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic p,
    output logic g,
    output logic s,
    output logic cout
);

    assign p    = a ^ b;
    assign g    = a & b;
    assign s    = p ^ cin;
    assign cout = g | (p & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder with registered outputs; subtraction is
// available when BIT_SERIAL_ADDER_SUB_EN is defined.
module bit_serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    bit_serial_adder_if.slave bus
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             prop_acc_q, prop_acc_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             prop_all_q, prop_all_d;

    logic sub_sel;
    logic bit_p, bit_g, bit_s, bit_c;
    logic cell_g_unused;

`ifdef BIT_SERIAL_ADDER_SUB_EN
    assign sub_sel = bus.sub;
`else
    assign sub_sel = 1'b0;
`endif

    pg_bit_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .p    (bit_p),
        .g    (bit_g),
        .s    (bit_s),
        .cout (bit_c)
    );

    // The generate term is already folded into the cell's carry-out.
    assign cell_g_unused = bit_g;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        prop_acc_d = prop_acc_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        prop_all_d = prop_all_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SHIFT;
                    a_sh_d     = bus.a;
                    b_sh_d     = sub_sel ? ~bus.b : bus.b;
                    cnt_d      = '0;
                    carry_d    = sub_sel;
                    prop_acc_d = 1'b1;
                end
            end
            SHIFT: begin
                // WIDTH bit steps, then one step that publishes the result.
                if (cnt_q == LAST_CNT) begin
                    state_d    = DONE;
                    sum_d      = acc_q;
                    cout_d     = carry_q;
                    prop_all_d = prop_acc_q;
                end else begin
                    a_sh_d     = a_sh_q >> 1;
                    b_sh_d     = b_sh_q >> 1;
                    acc_d      = {bit_s, acc_q[WIDTH-1:1]};
                    carry_d    = bit_c;
                    prop_acc_d = prop_acc_q & bit_p;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status flags are registered from the next state so they line up with it.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            prop_acc_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            prop_all_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            prop_acc_q <= prop_acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            prop_all_q <= prop_all_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.prop_all = prop_all_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder: directed cases, busy-start rejection,
// mid-operation reset and a few random additions.
module tb_bit_serial_adder;

    localparam int W      = 8;
    localparam int BUDGET = 40;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         prop_all;
    } exp_t;

    logic clk;
    logic rst_n;

    bit_serial_adder_if #(.WIDTH(W)) bus ();

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           done_cnt = 0;
    logic [W-1:0] last_sum = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Independent arithmetic model: whole-word sum rather than a bit loop.
    function automatic exp_t model(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic sub_v);
        logic [W-1:0] bo;
        logic [W:0]   tot;
        exp_t         e;
        bo         = sub_v ? ~b_v : b_v;
        tot        = {1'b0, a_v} + {1'b0, bo} + {{W{1'b0}}, sub_v};
        e.sum      = tot[W-1:0];
        e.cout     = tot[W];
        e.prop_all = &(a_v ^ bo);
        return e;
    endfunction

    // Call at a falling edge; the next rising edge accepts the request.
    task automatic drive_start(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic sub_v);
        bus.start = 1'b1;
        bus.a     = a_v;
        bus.b     = b_v;
`ifdef BIT_SERIAL_ADDER_SUB_EN
        bus.sub   = sub_v;
`endif
        sb_q.push_back(model(a_v, b_v, sub_v));
    endtask

    // poke_k >= 0 re-pulses start in that SHIFT cycle; poke_done re-pulses it in DONE.
    task automatic wait_result(input int poke_k, input bit poke_done);
        int   k;
        exp_t e;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (bus.done !== 1'b1 && k < BUDGET) begin
            if (k == 3) check("hold_sum", bus.sum, last_sum);
            if (k == poke_k) begin
                bus.a = 8'hF0;
                bus.b = 8'h0F;
            end
            bus.start = (k == poke_k);
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        if (bus.done !== 1'b1) begin
            check("done_timeout", 0, 1);
            return;
        end
        // done is high after edge N+W+1, so a clocked sampler sees it at edge N+W+2.
        check("latency", k + 1, W + 2);
        check("busy_in_done", bus.busy, 1);
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        check("sum", bus.sum, e.sum);
        check("cout", bus.cout, e.cout);
        check("prop_all", bus.prop_all, e.prop_all);
        last_sum = e.sum;
        if (poke_done) begin
            bus.a     = 8'hF0;
            bus.b     = 8'h0F;
            bus.start = 1'b1;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("done_pulse", bus.done, 0);
        if (poke_done) begin
            check("done_start_ignored", bus.busy, 0);
            repeat (4) @(negedge clk);
            check("after_sum", bus.sum, e.sum);
            check("after_cout", bus.cout, e.cout);
            check("after_prop", bus.prop_all, e.prop_all);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic sub_v);
        drive_start(a_v, b_v, sub_v);
        wait_result(-1, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_sum"}, bus.sum, 0);
        check({tag, "_cout"}, bus.cout, 0);
        check({tag, "_prop"}, bus.prop_all, 0);
    endtask

    initial begin
        int           dc0;
        logic [W-1:0] ra, rb;

        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
        bus.sub   = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h03, 8'h05, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'hAA, 8'h55, 1'b0);
`ifdef BIT_SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b1);
        run_op(8'h07, 8'h05, 1'b1);
`endif

        // Start during SHIFT and during DONE must both be ignored.
        dc0 = done_cnt;
        drive_start(8'h01, 8'h01, 1'b0);
        wait_result(2, 1'b1);
        check("single_done", done_cnt - dc0, 1);

        // Reset in the fourth SHIFT cycle, then restart on the first edge after release.
        dc0 = done_cnt;
        drive_start(8'h3C, 8'h0F, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1 check_zero_outputs("mid_rst");
        sb_q.delete();
        last_sum = '0;
        repeat (2) @(negedge clk);
        check("rst_no_done", done_cnt - dc0, 0);
        rst_n = 1'b1;
        drive_start(8'h3C, 8'h0F, 1'b0);
        wait_result(-1, 1'b0);
        check("rst_one_done", done_cnt - dc0, 1);

        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 1'b0);
        end

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
